// File: rtl/add_operand_queue.sv
// add_operand_queue: operand-pair FIFO that feeds an external combinational
// AddOp unit and registers its sum into a valid/ready output stage.
// Optional build macro: ADD_OPERAND_QUEUE_BYPASS_EN. When it is defined, an
// empty queue forwards the incoming pair straight to the AddOp unit. The
// result is then registered at the accept edge, giving 1-edge latency.
module add_operand_queue #(
    parameter int OPERAND_WIDTH = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPERAND_WIDTH-1:0]   in_lhs,
    input  logic [OPERAND_WIDTH-1:0]   in_rhs,
    output logic [OPERAND_WIDTH-1:0]   op_lhs,
    output logic [OPERAND_WIDTH-1:0]   op_rhs,
    input  logic [OPERAND_WIDTH-1:0]   op_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPERAND_WIDTH-1:0]   out_result,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [OPERAND_WIDTH-1:0] lhs_mem [DEPTH];
    logic [OPERAND_WIDTH-1:0] rhs_mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;

    logic has_head;
    logic can_load;
    logic accept;
    logic bypass;
    logic load;
    logic push;
    logic pop;

    // Handshake decode; in_ready depends only on registered occupancy and reset.
    always_comb begin
        has_head = (count != '0);
        can_load = !out_valid || out_ready;
        in_ready = rst_n && (count < DEPTH_C);
        accept   = in_valid && in_ready;
`ifdef ADD_OPERAND_QUEUE_BYPASS_EN
        bypass   = !has_head && accept && can_load;
`else
        bypass   = 1'b0;
`endif
        pop      = has_head && can_load;
        load     = pop || bypass;
        push     = accept && !bypass;
    end

    // Operand selection toward the AddOp unit: head entry, bypassed input, or zero.
    always_comb begin
        op_lhs = '0;
        op_rhs = '0;
        if (has_head) begin
            op_lhs = lhs_mem[rd_ptr];
            op_rhs = rhs_mem[rd_ptr];
        end
`ifdef ADD_OPERAND_QUEUE_BYPASS_EN
        else if (accept) begin
            op_lhs = in_lhs;
            op_rhs = in_rhs;
        end
`endif
    end

    // Queue storage; contents are don't-care until count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            lhs_mem[wr_ptr] <= in_lhs;
            rhs_mem[wr_ptr] <= in_rhs;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Output register: load a new sum when free or draining, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_result <= op_result;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/add_operand_queue.md
ADD_OPERAND_QUEUE -- requirements
Module: add_operand_queue

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH, default 32: width of lhs, rhs and result.
REQ-002 SHALL have parameter DEPTH, default 4: operand-pair queue entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  queue can accept a pair.
REQ-007 SHALL have port in_lhs  input  OPERAND_WIDTH  upstream left operand.
REQ-008 SHALL have port in_rhs  input  OPERAND_WIDTH  upstream right operand.
REQ-009 SHALL have port op_lhs  output  OPERAND_WIDTH  left operand to the AddOp unit.
REQ-010 SHALL have port op_rhs  output  OPERAND_WIDTH  right operand to the AddOp unit.
REQ-011 SHALL have port op_result  input  OPERAND_WIDTH  combinational sum returned by the AddOp unit.
REQ-012 SHALL have port out_valid  output  1  registered result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_result  output  OPERAND_WIDTH  registered sum.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  queue occupancy, 0..DEPTH.

Function
REQ-016 SHALL accept a pair on a rising edge where in_valid && in_ready; write it at the write pointer.
REQ-017 SHALL drive in_ready = (count < DEPTH), registered-state only; no combinational path from out_ready.
REQ-018 SHALL drive op_lhs/op_rhs from the head entry when count > 0, else all-zero.
REQ-019 SHALL load out_result <= op_result and pop the head on an edge where count > 0 && (!out_valid || out_ready).
REQ-020 SHALL set out_valid on a load edge; clear it on an edge where out_valid && out_ready and no load occurs.
REQ-021 SHALL hold out_result and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL sustain one result per cycle when out_ready stays high and input arrives every cycle.
REQ-023 SHALL give latency of 2 edges: pair accepted at edge E0 appears with out_valid after E1.
REQ-024 SHALL handle simultaneous push and pop: count unchanged, both pointers advance.
REQ-025 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entry.
REQ-026 SHALL compute no arithmetic internally; sum width and overflow wrap are the AddOp unit's (result truncated to OPERAND_WIDTH).
REQ-027 SHALL preserve FIFO order: results leave in acceptance order.

Reset
REQ-028 SHALL, while rst_n low, force count=0, pointers=0, out_valid=0, out_result=0, in_ready=0, op_lhs=op_rhs=0.
REQ-029 SHALL drop all queued pairs and any pending result on reset assertion mid-operation; no output after release until new input.
REQ-030 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with ADD_OPERAND_QUEUE_BYPASS_EN defined, when count == 0 and in_valid, drive op_lhs/op_rhs from in_lhs/in_rhs and, if load condition (!out_valid || out_ready) holds, load the result at the accept edge without enqueueing (1-edge latency).
REQ-032 SHALL, without ADD_OPERAND_QUEUE_BYPASS_EN, always enqueue first (2-edge latency, REQ-023); in_ready unchanged in both builds.

Verification
REQ-033 SHALL cover single pair: lhs=3, rhs=4, out_ready=1 -> out_result=7 with out_valid after E1 (after E0 with bypass).
REQ-034 SHALL cover overflow: lhs=0xFFFFFFFF, rhs=2 -> out_result=0x00000001.
REQ-035 SHALL cover fill: out_ready=0, push 5 pairs (DEPTH=4) -> 1 in out register, count=4, in_ready=0; then out_ready=1 -> 5 results in order, count returns 0.
REQ-036 SHALL cover wrap: 10 back-to-back pairs (i, 100*i), out_ready=1 -> outputs 101*i in order, one per cycle.
REQ-037 SHALL cover backpressure: out_ready toggled 1/0 each cycle -> out_result stable while stalled; no loss or duplication.
REQ-038 SHALL cover mid-run reset: rst_n low with count=3, out_valid=1 -> count=0, out_valid=0 immediately; in_ready=1 first cycle after release.
